neuron_seq_mac: RTL and testbench

- Parametrised, time-multiplexed successor to the fixed 4-input pipelined neuron.
- Computes y = sat(ReLU((b + sum over i of w[i]*x[i]) >>> SHIFT)) for N_IN inputs using a single multiply-accumulate datapath, one term per cycle.
- Adds synchronous reset, busy/ready handshake and output saturation.
- Sits between layer-input registers and the next layer's input bus in the Morse decoder network.

---
 rtl/neuron_seq_mac.sv | 139 +++++++++++++
 tb/tb_neuron_seq_mac.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_seq_mac.sv
// Time-multiplexed neuron: y = sat(ReLU((b + sum w[i]*x[i]) >>> SHIFT)).
// The datapath has one multiply-accumulate unit and applies one term per cycle.
// Ports:
//   clk_i     rising-edge clock
//   reset_i   synchronous active-high reset; it overrides new_i
//   new_i     start request; w_i, x_i and b_i are sampled on the same edge
//   w_i       N_IN signed weights, w[i] = w_i[i*W_W +: W_W]
//   x_i       N_IN unsigned inputs, x[i] = x_i[i*X_W +: X_W]
//   b_i       signed bias
//   y_o       unsigned saturated result, held until the next result
//   ready_o   one-cycle pulse when y_o updates
//   busy_o    high while a computation is in progress; new_i is ignored then
module neuron_seq_mac #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned W_W   = 8,
  parameter int unsigned X_W   = 8,
  parameter int unsigned ACC_W = 16,
  parameter int unsigned SHIFT = 2,
  parameter int unsigned Y_W   = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  new_i,
  input  logic [N_IN*W_W-1:0]   w_i,
  input  logic [N_IN*X_W-1:0]   x_i,
  input  logic [W_W-1:0]        b_i,
  output logic [Y_W-1:0]        y_o,
  output logic                  ready_o,
  output logic                  busy_o
);

  localparam int unsigned PROD_W = W_W + X_W + 1;
  localparam int unsigned IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);
  localparam logic [ACC_W-1:0] Y_MAX    = ACC_W'((2 ** Y_W) - 1);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_e;

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [N_IN*W_W-1:0]      w_q, w_d;
  logic [N_IN*X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]           y_q, y_d;
  logic                     ready_q, ready_d;
  logic                     busy_q, busy_d;

  logic signed [W_W-1:0]    w_sel;
  logic [X_W-1:0]           x_sel;
  logic signed [PROD_W-1:0] w_ext, x_ext, prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic [ACC_W-1:0]         acc_shr;

  // Current term: signed weight times zero-extended input, then wrapping add.
  always_comb begin
    w_sel   = w_q[32'(idx_q) * W_W +: W_W];
    x_sel   = x_q[32'(idx_q) * X_W +: X_W];
    w_ext   = PROD_W'(w_sel);
    x_ext   = PROD_W'(x_sel);
    prod    = w_ext * x_ext;
    acc_sum = acc_q + ACC_W'(prod);
    acc_shr = acc_q >>> SHIFT;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    w_d     = w_q;
    x_d     = x_q;
    y_d     = y_q;
    ready_d = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (new_i) begin
          w_d     = w_i;
          x_d     = x_i;
          acc_d   = ACC_W'($signed(b_i));
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_sum;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // A negative sum clamps to zero; otherwise the scaled sum saturates at all ones.
        if (acc_q[ACC_W-1]) begin
          y_d = '0;
        end else if (acc_shr > Y_MAX) begin
          y_d = '1;
        end else begin
          y_d = Y_W'(acc_shr);
        end
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      w_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      w_q     <= w_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign y_o     = y_q;
  assign ready_o = ready_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_neuron_seq_mac.sv
// Bench for neuron_seq_mac: three instances (N_IN = 1, 4, 8) share the operand buses.
module tb_neuron_seq_mac;

  logic        clk = 1'b0;
  logic        reset;
  logic        new1, new4, new8;
  logic [63:0] w_bus, x_bus;
  logic [7:0]  b_bus;
  logic [7:0]  y1, y4, y8;
  logic        r1, r4, r8;
  logic        bz1, bz4, bz8;

  int          sel_cur;
  logic [7:0]  cur_y;
  logic        cur_r, cur_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  neuron_seq_mac #(.N_IN(1), .ACC_W(20)) u1 (
    .clk_i(clk), .reset_i(reset), .new_i(new1),
    .w_i(w_bus[7:0]), .x_i(x_bus[7:0]), .b_i(b_bus),
    .y_o(y1), .ready_o(r1), .busy_o(bz1));

  neuron_seq_mac #(.N_IN(4)) u4 (
    .clk_i(clk), .reset_i(reset), .new_i(new4),
    .w_i(w_bus[31:0]), .x_i(x_bus[31:0]), .b_i(b_bus),
    .y_o(y4), .ready_o(r4), .busy_o(bz4));

  neuron_seq_mac #(.N_IN(8), .ACC_W(20)) u8 (
    .clk_i(clk), .reset_i(reset), .new_i(new8),
    .w_i(w_bus), .x_i(x_bus), .b_i(b_bus),
    .y_o(y8), .ready_o(r8), .busy_o(bz8));

  always_comb begin
    case (sel_cur)
      1:       begin cur_y = y1; cur_r = r1; cur_b = bz1; end
      8:       begin cur_y = y8; cur_r = r8; cur_b = bz8; end
      default: begin cur_y = y4; cur_r = r4; cur_b = bz4; end
    endcase
  end

  typedef struct {
    string       name;
    logic [31:0] w;
    logic [31:0] x;
    logic [7:0]  b;
    int          exp_y;
  } vec_t;

  vec_t vecs[6];

  // Reference: plain integer sum, wrapped to acc_w bits, then ReLU, shift and clamp.
  function automatic int ref_y(int n, logic [63:0] wv, logic [63:0] xv,
                               logic [7:0] bv, int acc_w);
    longint s = longint'($signed(bv));
    longint m = longint'(1) << acc_w;
    for (int i = 0; i < n; i++)
      s += longint'($signed(wv[i*8 +: 8])) * longint'(xv[i*8 +: 8]);
    s = s & (m - 1);
    if (s >= (m >> 1)) s -= m;
    if (s < 0) return 0;
    s = s / 4;
    return (s > 255) ? 255 : int'(s);
  endfunction

  task automatic check(string name, longint act, longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_new(int sel, logic v);
    case (sel)
      1:       new1 = v;
      8:       new8 = v;
      default: new4 = v;
    endcase
  endtask

  // Present operands with new asserted and let the accepting edge pass.
  task automatic start(int sel, logic [63:0] wv, logic [63:0] xv, logic [7:0] bv);
    sel_cur = sel;
    w_bus = wv;
    x_bus = xv;
    b_bus = bv;
    set_new(sel, 1'b1);
    tick();
  endtask

  // Called just after the accepting edge; returns during the ready cycle.
  task automatic wait_result(int sel, int exp, string name);
    logic bad = 1'b0;
    set_new(sel, 1'b0);
    w_bus = {$urandom, $urandom};
    x_bus = {$urandom, $urandom};
    b_bus = 8'($urandom);
    check({name, ":busy_start"}, longint'(cur_b), 1);
    for (int c = 1; c <= sel + 1; c++) begin
      tick();
      if (c < sel + 1 && (cur_r !== 1'b0 || cur_b !== 1'b1)) bad = 1'b1;
    end
    check({name, ":early"}, longint'(bad), 0);
    check({name, ":ready"}, longint'(cur_r), 1);
    check({name, ":busy_end"}, longint'(cur_b), 0);
    check({name, ":y"}, longint'(cur_y), longint'(exp));
  endtask

  task automatic do_op(int sel, logic [63:0] wv, logic [63:0] xv, logic [7:0] bv,
                       int exp, string name, bit follow);
    start(sel, wv, xv, bv);
    wait_result(sel, exp, name);
    if (follow) begin
      tick();
      check({name, ":ready_drop"}, longint'(cur_r), 0);
    end
  endtask

  localparam logic [63:0] W_C1 = 64'h04030201;
  localparam logic [63:0] X_C1 = 64'h281E140A;

  initial begin
    logic bad;
    vecs[0] = '{"basic",  32'h04030201, 32'h281E140A, 8'd0,   75};
    vecs[1] = '{"neg",    32'hFFFFFFFF, 32'h32323232, 8'd0,   0};
    vecs[2] = '{"bias",   32'hFFFFFFFF, 32'h00000000, 8'd100, 25};
    vecs[3] = '{"negb",   32'hFFFFFFFF, 32'h00000000, 8'hFB,  0};
    vecs[4] = '{"sat",    32'h00000040, 32'h000000FF, 8'd0,   255};
    vecs[5] = '{"wrap",   32'h7F7F7F7F, 32'hFFFFFFFF, 8'h7F,  0};

    reset = 1'b1;
    new1 = 1'b0; new4 = 1'b0; new8 = 1'b0;
    w_bus = '0; x_bus = '0; b_bus = '0;
    sel_cur = 4;
    // new asserted during reset must not start anything
    new4 = 1'b1;
    tick(); tick();
    check("rst:busy4", longint'(bz4), 0);
    check("rst:ready4", longint'(r4), 0);
    check("rst:y4", longint'(y4), 0);
    check("rst:busy1", longint'(bz1), 0);
    check("rst:busy8", longint'(bz8), 0);
    new4 = 1'b0;
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++)
      do_op(4, 64'(vecs[i].w), 64'(vecs[i].x), vecs[i].b, vecs[i].exp_y, vecs[i].name, 1'b1);

    // Second request two cycles after acceptance is dropped.
    start(4, W_C1, X_C1, 8'd0);
    set_new(4, 1'b0);
    tick();
    w_bus = 64'h00000040; x_bus = 64'h000000FF; b_bus = 8'd0;
    set_new(4, 1'b1);
    tick();
    set_new(4, 1'b0);
    check("ign:busy_mid", longint'(cur_b), 1);
    tick(); tick();
    check("ign:not_early", longint'(cur_r), 0);
    tick();
    check("ign:ready", longint'(cur_r), 1);
    check("ign:y", longint'(cur_y), 75);
    tick();
    check("ign:no_queue_ready", longint'(cur_r), 0);
    check("ign:no_queue_busy", longint'(cur_b), 0);

    // Request held through the ready cycle is accepted back to back.
    do_op(4, W_C1, X_C1, 8'd0, 75, "b2b_first", 1'b0);
    start(4, W_C1, 64'h0, 8'd100);
    check("b2b:ready_drop", longint'(cur_r), 0);
    wait_result(4, 25, "b2b_second");
    tick();
    check("b2b:single_pulse", longint'(cur_r), 0);

    // Reset two edges into a computation aborts it.
    start(4, W_C1, X_C1, 8'd0);
    set_new(4, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort:ready", longint'(cur_r), 0);
    check("abort:y", longint'(cur_y), 0);
    check("abort:busy", longint'(cur_b), 0);
    bad = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (cur_r !== 1'b0 || cur_b !== 1'b0) bad = 1'b1;
    end
    check("abort:quiet", longint'(bad), 0);
    do_op(4, W_C1, X_C1, 8'd0, 75, "after_abort", 1'b1);

    // Randomised operands on all three widths against the reference.
    foreach (vecs[i]) begin end
    for (int k = 0; k < 3; k++) begin
      int sel   = (k == 0) ? 1 : (k == 1) ? 8 : 4;
      int acc_w = (sel == 4) ? 16 : 20;
      for (int it = 0; it < 15; it++) begin
        logic [63:0] wv = {$urandom, $urandom};
        logic [63:0] xv = {$urandom, $urandom};
        logic [7:0]  bv = 8'($urandom);
        // Bias towards positive weights sometimes so the saturating path is exercised.
        if (it % 3 == 0) wv = wv & 64'h7F7F7F7F7F7F7F7F;
        do_op(sel, wv, xv, bv, ref_y(sel, wv, xv, bv, acc_w),
              $sformatf("rand_n%0d_%0d", sel, it), bit'(it % 2));
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
